// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants for the two-master Wishbone arbiter.
// Holds the FSM state encoding, bus width defaults and the default
// watchdog timeout used when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

   // Bus width defaults
   localparam int unsigned ADR_W_DEF          = 32;
   localparam int unsigned DAT_W_DEF          = 32;

   // Watchdog defaults; the counter is wide enough for the largest timeout (65535)
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam int unsigned WD_CNT_W           = 16;

   // Arbiter states; the encoding doubles as the one-hot {M1,M0} grant status
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_GNT0 = 2'b01;
   localparam logic [1:0] ST_GNT1 = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: bus timeout for the arbiter slave side.
// Counts strobe cycles that see no ACK. When the count reaches
// TIMEOUT_CYCLES the access is terminated: ERR pulses for one cycle and
// the slave strobe is suppressed in that cycle. An ACK in the same cycle
// wins. Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic stb_in,    // granted master's strobe, already gated by its CYC
   input  logic ack_in,    // OR of all slave ACKs
   output logic stb_out,   // strobe towards the slave decoder
   output logic err_out    // one-cycle timeout error
);

   logic [WD_CNT_W-1:0] cnt_q;
   logic [WD_CNT_W-1:0] cnt_d;
   logic                timeout;

   // Timeout detection and next count. A grant change always passes through
   // IDLE, where the strobe is low, so the count is already clear by then.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cnt_d   = '0;
      timeout = stb_in && !ack_in && (cnt_q == WD_CNT_W'(TIMEOUT_CYCLES));
      if (stb_in && !ack_in && !timeout) begin
         cnt_d = cnt_q + WD_CNT_W'(1);
      end
      stb_out = stb_in && !timeout;
      err_out = timeout;
   end

   // Count register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cnt_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one peripheral Wishbone bus
// between the CPU port (M0) and the DMA port (M1). A grant is held for the
// whole CYC burst and every hand-over passes through one IDLE cycle.
// Optional bus watchdog: define WB_ARB_TIMEOUT_EN to build it; without it
// the ERR outputs are tied low and an unacknowledged access waits forever.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned ADR_W          = ADR_W_DEF,
   parameter int unsigned DAT_W          = DAT_W_DEF
) (
   input  logic             iCLK,
   input  logic             iRST,
   // Master 0 (CPU)
   input  logic             iM0_CYC,
   input  logic             iM0_STB,
   input  logic             iM0_WE,
   input  logic [ADR_W-1:0] iM0_ADR,
   input  logic [DAT_W-1:0] iM0_DAT,
   output logic             oM0_ACK,
   output logic             oM0_ERR,
   output logic [DAT_W-1:0] oM0_DAT,
   // Master 1 (DMA)
   input  logic             iM1_CYC,
   input  logic             iM1_STB,
   input  logic             iM1_WE,
   input  logic [ADR_W-1:0] iM1_ADR,
   input  logic [DAT_W-1:0] iM1_DAT,
   output logic             oM1_ACK,
   output logic             oM1_ERR,
   output logic [DAT_W-1:0] oM1_DAT,
   // Slave side (towards the peripheral address decoder)
   output logic             oS_CYC,
   output logic             oS_STB,
   output logic             oS_WE,
   output logic [ADR_W-1:0] oS_ADR,
   output logic [DAT_W-1:0] oS_DAT,
   input  logic             iS_ACK,
   input  logic [DAT_W-1:0] iS_DAT,
   // Grant status {M1,M0}
   output logic [1:0]       oGNT
);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       last_q;     // most recently granted master (1 = M1)
   logic       last_d;
   logic       stb_raw;    // granted master's strobe, gated by its CYC
   logic       wd_err;
   logic       gnt0;
   logic       gnt1;

   // Next-state logic: round-robin grant from IDLE, hold while CYC stays high
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (iM0_CYC && iM1_CYC) begin
               state_d = last_q ? ST_GNT0 : ST_GNT1;
            end else if (iM0_CYC) begin
               state_d = ST_GNT0;
            end else if (iM1_CYC) begin
               state_d = ST_GNT1;
            end
            if (state_d == ST_GNT0) last_d = 1'b0;
            if (state_d == ST_GNT1) last_d = 1'b1;
         end
         ST_GNT0: if (!iM0_CYC) state_d = ST_IDLE;
         ST_GNT1: if (!iM1_CYC) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and round-robin history; last=1 lets M0 win the first tie
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign gnt0 = (state_q == ST_GNT0);
   assign gnt1 = (state_q == ST_GNT1);
   assign oGNT = state_q;

   // Slave-side mux; dropping CYC aborts the access, so STB is gated by CYC
   always_comb begin
      oS_CYC  = 1'b0;
      stb_raw = 1'b0;
      oS_WE   = 1'b0;
      oS_ADR  = '0;
      oS_DAT  = '0;
      if (gnt0) begin
         oS_CYC  = iM0_CYC;
         stb_raw = iM0_CYC && iM0_STB;
         oS_WE   = iM0_WE;
         oS_ADR  = iM0_ADR;
         oS_DAT  = iM0_DAT;
      end else if (gnt1) begin
         oS_CYC  = iM1_CYC;
         stb_raw = iM1_CYC && iM1_STB;
         oS_WE   = iM1_WE;
         oS_ADR  = iM1_ADR;
         oS_DAT  = iM1_DAT;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .stb_in  (stb_raw),
      .ack_in  (iS_ACK),
      .stb_out (oS_STB),
      .err_out (wd_err)
   );
`else
   assign oS_STB = stb_raw;
   assign wd_err = 1'b0;
`endif

   // Return path: only the granted master sees ACK, ERR and read data
   always_comb begin
      oM0_ACK = iS_ACK && gnt0;
      oM1_ACK = iS_ACK && gnt1;
      oM0_ERR = wd_err && gnt0;
      oM1_ERR = wd_err && gnt1;
      oM0_DAT = gnt0 ? iS_DAT : '0;
      oM1_DAT = gnt1 ? iS_DAT : '0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter.
// Directed scenarios for reset, single master, ties, burst hold, read-data
// gating, watchdog (when WB_ARB_TIMEOUT_EN is defined) and reset mid-burst,
// followed by a randomized run against a behavioural ownership model.
module tb_wb_arbiter;

   localparam int TO = 8;

   logic        iCLK, iRST;
   logic        iM0_CYC, iM0_STB, iM0_WE, iM1_CYC, iM1_STB, iM1_WE;
   logic [31:0] iM0_ADR, iM0_DAT, iM1_ADR, iM1_DAT;
   logic        oM0_ACK, oM0_ERR, oM1_ACK, oM1_ERR;
   logic [31:0] oM0_DAT, oM1_DAT;
   logic        oS_CYC, oS_STB, oS_WE;
   logic [31:0] oS_ADR, oS_DAT;
   logic        iS_ACK;
   logic [31:0] iS_DAT;
   logic [1:0]  oGNT;

   int errors = 0;
   int checks = 0;

   wb_arbiter #(.TIMEOUT_CYCLES(TO), .ADR_W(32), .DAT_W(32)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iM0_CYC(iM0_CYC), .iM0_STB(iM0_STB), .iM0_WE(iM0_WE), .iM0_ADR(iM0_ADR), .iM0_DAT(iM0_DAT),
      .oM0_ACK(oM0_ACK), .oM0_ERR(oM0_ERR), .oM0_DAT(oM0_DAT),
      .iM1_CYC(iM1_CYC), .iM1_STB(iM1_STB), .iM1_WE(iM1_WE), .iM1_ADR(iM1_ADR), .iM1_DAT(iM1_DAT),
      .oM1_ACK(oM1_ACK), .oM1_ERR(oM1_ERR), .oM1_DAT(oM1_DAT),
      .oS_CYC(oS_CYC), .oS_STB(oS_STB), .oS_WE(oS_WE), .oS_ADR(oS_ADR), .oS_DAT(oS_DAT),
      .iS_ACK(iS_ACK), .iS_DAT(iS_DAT), .oGNT(oGNT)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic idle_inputs();
      iM0_CYC = 0; iM0_STB = 0; iM0_WE = 0; iM0_ADR = '0; iM0_DAT = '0;
      iM1_CYC = 0; iM1_STB = 0; iM1_WE = 0; iM1_ADR = '0; iM1_DAT = '0;
      iS_ACK = 0; iS_DAT = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      iRST = 1'b1;
      iM0_CYC = 1; iM0_STB = 1; iM1_CYC = 1; iM1_STB = 1;
      iS_ACK = 1; iS_DAT = 32'h1234_5678;
      #12;
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", oGNT); end
      checks++; if ({oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT} !== 67'd0) begin errors++;
         $display("FAIL reset_slave: got %h want 0", {oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT}); end
      checks++; if ({oM0_ACK, oM0_ERR, oM0_DAT, oM1_ACK, oM1_ERR, oM1_DAT} !== 68'd0) begin errors++;
         $display("FAIL reset_master: got %h want 0", {oM0_ACK, oM0_ERR, oM0_DAT, oM1_ACK, oM1_ERR, oM1_DAT}); end
      idle_inputs();
      #10 iRST = 1'b0;
      tick();
   endtask

   task automatic test_tie();
      iM0_CYC = 1; iM0_STB = 1; iM0_ADR = 32'h0200_1000;
      iM1_CYC = 1; iM1_STB = 1; iM1_ADR = 32'h0200_2000;
      #1;
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL tie_req_cycle: got %b want 00", oGNT); end
      tick();
      checks++; if (oGNT !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", oGNT); end
      checks++; if (oS_ADR !== 32'h0200_1000) begin errors++; $display("FAIL tie_first_adr: got %h want 02001000", oS_ADR); end
      iM0_CYC = 0; iM0_STB = 0;
      tick();
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL tie_idle_gap: got %b want 00", oGNT); end
      tick();
      checks++; if (oGNT !== 2'b10) begin errors++; $display("FAIL tie_second: got %b want 10", oGNT); end
      checks++; if (oS_ADR !== 32'h0200_2000) begin errors++; $display("FAIL tie_second_adr: got %h want 02002000", oS_ADR); end
      iM1_CYC = 0; iM1_STB = 0;
      tick();
      iM0_CYC = 1; iM0_STB = 1; iM1_CYC = 1; iM1_STB = 1;
      tick();
      checks++; if (oGNT !== 2'b01) begin errors++; $display("FAIL tie_repeat: got %b want 01", oGNT); end
      idle_inputs();
      tick();
   endtask

   task automatic test_single_m0();
      iM0_CYC = 1; iM0_STB = 1; iM0_WE = 1; iM0_ADR = 32'h0200_1000; iM0_DAT = 32'hA5A5_0001;
      #1;
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL single_req_cycle: got %b want 00", oGNT); end
      tick();
      checks++; if (oGNT !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", oGNT); end
      checks++; if ({oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT} !== {3'b111, 32'h0200_1000, 32'hA5A5_0001}) begin errors++;
         $display("FAIL single_slave: got %h want %h", {oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT}, {3'b111, 32'h0200_1000, 32'hA5A5_0001}); end
      checks++; if (oM0_ACK !== 1'b0) begin errors++; $display("FAIL single_no_early_ack: got %b want 0", oM0_ACK); end
      tick();
      iS_ACK = 1;
      #1;
      checks++; if ({oM0_ACK, oM1_ACK} !== 2'b10) begin errors++; $display("FAIL single_ack: got %b want 10", {oM0_ACK, oM1_ACK}); end
      iM0_CYC = 0; iM0_STB = 0; iS_ACK = 0;
      #1;
      checks++; if ({oM0_ACK, oM1_ACK} !== 2'b00) begin errors++; $display("FAIL single_ack_end: got %b want 00", {oM0_ACK, oM1_ACK}); end
      tick();
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", oGNT); end
      idle_inputs();
   endtask

   task automatic test_burst_hold();
      iM1_CYC = 1; iM1_STB = 1; iM1_ADR = 32'h0200_3000;
      tick();
      iM0_CYC = 1; iM0_STB = 1; iM0_ADR = 32'h0200_1004;
      for (int i = 0; i < 4; i++) begin
         iM1_ADR = 32'h0200_3000 + 32'(4 * i);
         iS_ACK = 1;
         #1;
         checks++; if (oGNT !== 2'b10) begin errors++; $display("FAIL burst_gnt[%0d]: got %b want 10", i, oGNT); end
         checks++; if ({oM1_ACK, oM0_ACK} !== 2'b10) begin errors++; $display("FAIL burst_ack[%0d]: got %b want 10", i, {oM1_ACK, oM0_ACK}); end
         tick();
      end
      iM1_CYC = 0; iM1_STB = 0; iS_ACK = 0;
      tick();
      checks++; if (oGNT !== 2'b00) begin errors++; $display("FAIL burst_gap: got %b want 00", oGNT); end
      tick();
      checks++; if (oGNT !== 2'b01) begin errors++; $display("FAIL burst_handover: got %b want 01", oGNT); end
      idle_inputs();
      tick();
   endtask

   task automatic test_read_gating();
      iM1_CYC = 1; iM1_STB = 1; iM1_ADR = 32'h0200_2000; iS_DAT = 32'hDEAD_BEEF;
      #1;
      checks++; if (oM1_DAT !== 32'h0) begin errors++; $display("FAIL rd_before_gnt: got %h want 0", oM1_DAT); end
      tick();
      iS_ACK = 1;
      #1;
      checks++; if (oM1_DAT !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m1_dat: got %h want deadbeef", oM1_DAT); end
      checks++; if (oM0_DAT !== 32'h0) begin errors++; $display("FAIL rd_m0_dat: got %h want 0", oM0_DAT); end
      idle_inputs();
      tick();
   endtask

   task automatic test_watchdog();
      iM0_CYC = 1; iM0_STB = 1; iM0_ADR = 32'h0200_4000;
      tick();
`ifdef WB_ARB_TIMEOUT_EN
      // STB cycles 1..8 wait; cycle 9 times out; cycle 10 starts a fresh count
      for (int k = 1; k <= TO + 2; k++) begin
         if (k == TO + 1) begin
            checks++; if ({oM0_ERR, oS_STB, oM1_ERR} !== 3'b100) begin errors++; $display("FAIL wd_err_cycle%0d: got %b want 100", k, {oM0_ERR, oS_STB, oM1_ERR}); end
         end else begin
            checks++; if ({oM0_ERR, oS_STB} !== 2'b01) begin errors++; $display("FAIL wd_wait_cycle%0d: got %b want 01", k, {oM0_ERR, oS_STB}); end
         end
         tick();
      end
      iM0_CYC = 0; iM0_STB = 0;
      tick();
      iM0_CYC = 1; iM0_STB = 1;
      tick();
      for (int k = 1; k <= TO; k++) tick();
      iS_ACK = 1;
      #1;
      checks++; if ({oM0_ACK, oM0_ERR, oS_STB} !== 3'b101) begin errors++; $display("FAIL wd_ack_wins: got %b want 101", {oM0_ACK, oM0_ERR, oS_STB}); end
`else
      // Without the watchdog the access simply waits
      for (int k = 1; k <= 3 * TO; k++) begin
         checks++; if ({oM0_ERR, oS_STB} !== 2'b01) begin errors++; $display("FAIL nowd_wait_cycle%0d: got %b want 01", k, {oM0_ERR, oS_STB}); end
         tick();
      end
`endif
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_burst();
      iM1_CYC = 1; iM1_STB = 1; iM1_ADR = 32'h0200_3000; iS_ACK = 1;
      tick();
      checks++; if ({oGNT, oS_STB, oM1_ACK} !== 4'b1011) begin errors++; $display("FAIL rstmid_pre: got %b want 1011", {oGNT, oS_STB, oM1_ACK}); end
      #2 iRST = 1'b1;
      #1;
      checks++; if ({oGNT, oS_STB, oM1_ACK} !== 4'b0000) begin errors++; $display("FAIL rstmid_async: got %b want 0000", {oGNT, oS_STB, oM1_ACK}); end
      #2 iRST = 1'b0;
      iS_ACK = 0;
      iM0_CYC = 1; iM0_STB = 1;
      tick();
      checks++; if (oGNT !== 2'b01) begin errors++; $display("FAIL rstmid_tie: got %b want 01", oGNT); end
      idle_inputs();
      tick();
   endtask

   // Randomized traffic against a model of bus ownership
   task automatic test_random();
      int          own;     // -1 nobody, else owning master
      int          lst;     // master granted most recently
      int          wcnt;    // consecutive unacknowledged strobe cycles
      bit          c0, c1;
      logic [1:0]  gnt_e;
      logic        stb_e, err_e;
      logic [66:0] slv_e;
      iRST = 1'b1;
      idle_inputs();
      #2 iRST = 1'b0;
      tick();
      own = -1; lst = 1; wcnt = 0; c0 = 0; c1 = 0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(7) == 0) c0 = ~c0;
         if ($urandom_range(7) == 0) c1 = ~c1;
         iM0_CYC = c0; iM0_STB = ($urandom_range(7) != 0); iM0_WE = 1'($urandom); iM0_ADR = $urandom; iM0_DAT = $urandom;
         iM1_CYC = c1; iM1_STB = ($urandom_range(7) != 0); iM1_WE = 1'($urandom); iM1_ADR = $urandom; iM1_DAT = $urandom;
         iS_ACK = ($urandom_range(3) == 0); iS_DAT = $urandom;
         #1;
         gnt_e = 2'b00; stb_e = 1'b0; slv_e = '0;
         if (own == 0) begin
            gnt_e = 2'b01; stb_e = iM0_CYC & iM0_STB;
            slv_e = {iM0_CYC, 1'b0, iM0_WE, iM0_ADR, iM0_DAT};
         end else if (own == 1) begin
            gnt_e = 2'b10; stb_e = iM1_CYC & iM1_STB;
            slv_e = {iM1_CYC, 1'b0, iM1_WE, iM1_ADR, iM1_DAT};
         end
         err_e = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         err_e = stb_e && !iS_ACK && (wcnt == TO);
`endif
         slv_e[65] = stb_e & ~err_e;
         checks++; if (oGNT !== gnt_e) begin errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", n, oGNT, gnt_e); end
         checks++; if ({oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT} !== slv_e) begin errors++;
            $display("FAIL rnd_slave@%0d: got %h want %h", n, {oS_CYC, oS_STB, oS_WE, oS_ADR, oS_DAT}, slv_e); end
         checks++; if ({oM0_ACK, oM0_ERR, oM0_DAT} !== ((own == 0) ? {iS_ACK, err_e, iS_DAT} : 34'd0)) begin errors++;
            $display("FAIL rnd_m0@%0d: got %h", n, {oM0_ACK, oM0_ERR, oM0_DAT}); end
         checks++; if ({oM1_ACK, oM1_ERR, oM1_DAT} !== ((own == 1) ? {iS_ACK, err_e, iS_DAT} : 34'd0)) begin errors++;
            $display("FAIL rnd_m1@%0d: got %h", n, {oM1_ACK, oM1_ERR, oM1_DAT}); end
         // Model update for the coming edge
         wcnt = (stb_e && !iS_ACK && !err_e) ? wcnt + 1 : 0;
         if (own == -1) begin
            if (c0 && c1) own = (lst == 1) ? 0 : 1;
            else if (c0)  own = 0;
            else if (c1)  own = 1;
            if (own != -1) lst = own;
         end else if ((own == 0 && !c0) || (own == 1 && !c1)) begin
            own = -1;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_single_m0();
      test_burst_hold();
      test_read_gating();
      test_watchdog();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master arbiter that shares the single peripheral Wishbone bus (Timer at 0x0200_1000, PWM at 0x0200_2000, PWM_1 at 0x0200_3000) between the CPU port (M0) and the DMA port (M1). It sits between the masters and the peripheral address decoder, granting one master at a time with round-robin fairness and holding the grant for a whole CYC burst. An optional bus watchdog terminates accesses that no slave acknowledges, e.g. an unmapped address.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles on STB without ACK before the watchdog raises ERR (range 2..65535).
- ADR_W, 32: address width.
- DAT_W, 32: data width.

- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iM0_CYC / iM1_CYC  in  1  master cycle (bus request)
- iM0_STB / iM1_STB  in  1  master strobe
- iM0_WE / iM1_WE  in  1  write enable
- iM0_ADR / iM1_ADR  in  ADR_W  address
- iM0_DAT / iM1_DAT  in  DAT_W  write data
- oM0_ACK / oM1_ACK  out  1  acknowledge, granted master only
- oM0_ERR / oM1_ERR  out  1  watchdog error, granted master only
- oM0_DAT / oM1_DAT  out  DAT_W  read data, granted master only, else 0
- oS_CYC, oS_STB, oS_WE  out  1  slave-side controls (oS_STB drives the decoder's strobe input)
- oS_ADR  out  ADR_W  slave address
- oS_DAT  out  DAT_W  slave write data
- iS_ACK  in  1  OR of all peripheral ACKs
- iS_DAT  in  DAT_W  muxed peripheral read data
- oGNT  out  2  one-hot grant status {M1,M0}; 00 when idle

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered `last` bit holds the most recently granted master.
- IDLE:
  - Only iM0_CYC set: go to GNT0.
  - Only iM1_CYC set: go to GNT1.
  - Both set: grant the master not equal to `last`.
  - Neither set: stay in IDLE.
- GNTx: stay while iMx_CYC=1. On iMx_CYC=0, go to IDLE; there is always exactly one idle cycle between grants.
- Slave-side outputs are combinational from the state:
  - GNTx: oS_* equal master x's inputs.
  - IDLE: all oS_* are 0.
- Return path:
  - oMx_ACK = iS_ACK & GNTx.
  - oMx_DAT = GNTx ? iS_DAT : 0.
  - The non-granted master sees ACK=0, ERR=0, DAT=0.
- `last` updates on entry to GNTx.
- A master dropping CYC mid-strobe aborts its access. The slave strobe drops in the same cycle.

## Timing
- Reset values:
  - state=IDLE, last=1 (M0 wins the first tie), watchdog count=0.
  - All oS_* = 0, oGNT=00, all oMx_ACK/ERR/DAT = 0.
- Grant latency: CYC sampled high at edge n means GNTx is active from edge n and oS_STB follows iMx_STB in cycle n+1. Worst case for the losing master is one full burst of the other master plus 2 cycles.
- ACK is a combinational pass-through with zero added latency; single-cycle slave ACKs support back-to-back strobes.
- Simultaneous CYC rise from both masters in IDLE: round-robin per `last`.
- The releasing master re-requesting in its release cycle is still subject to round-robin against a waiting peer.
- iRST asserted mid-burst: everything returns to reset values immediately (asynchronously), and any open access is lost.

## Configuration
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle with oS_STB=1 and iS_ACK=0. It clears on ACK, on STB=0, or on grant change.
  - In the cycle where count==TIMEOUT_CYCLES and iS_ACK=0, oMx_ERR=1 for one cycle, oS_STB is forced to 0 for that cycle, and the count clears.
  - ACK arriving in that same cycle wins: ERR stays 0.
- Undefined: no counter is built, oM0_ERR/oM1_ERR are tied to 0, and an unacknowledged access waits indefinitely.

## Structure
- Package wb_arb_pkg holds:
  - The state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10).
  - ADR_W/DAT_W defaults.
  - The default TIMEOUT_CYCLES.
- Sub-module wb_arb_watchdog holds the timeout counter plus ERR/STB-kill generation. It is instantiated only under WB_ARB_TIMEOUT_EN.

## Test plan
- Single master M0: CYC/STB write to 0x0200_1000, slave ACKs in 2 cycles. Expect oGNT=01 one cycle after CYC, oS_ADR=0x0200_1000, oM0_ACK pulse, oM1_ACK=0 throughout.
- Simultaneous CYC from both masters right after reset: M0 granted first. After M0 drops CYC there is 1 idle cycle, then oGNT=10. A repeat of the tie grants M0 again.
- Burst hold: M1 holds CYC over 4 strobes while M0 requests. oGNT stays 10 for all 4 ACKs, and M0 receives no ACK until granted.
- Read data gating: iS_DAT=0xDEAD_BEEF during M1 grant. Expect oM1_DAT=0xDEAD_BEEF and oM0_DAT=0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: M0 strobes 0x0200_4000 with no ACK. Expect oM0_ERR high exactly in the 9th STB cycle with oS_STB=0 in that cycle. A second run with ACK arriving in that cycle yields ACK and no ERR.
- Reset mid-burst: assert iRST during GNT1 with STB high. Expect oS_STB=0 and oGNT=00 immediately. After release, a tie grants M0.
